mem_port_arbiter: RTL and testbench

- Shares the single 16-bit memory port between two requesters.
- Instruction fetch needs a word pair: the opcode at PC and the prefetch/K16 word.
- Load/store needs one data word, read or write.
- The block sequences the two fetch beats back-to-back, arbitrates against load/store, and generates the `hold` stall that freezes the fetch unit and decoder until its pair is delivered.

---
 rtl/mem_port_arbiter_if.sv | 59 +++++
 rtl/mem_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - Signal bundle for the fetch, load/store and memory sides of mem_port_arbiter
//
// Groups every handshake and bus signal of the arbiter. The slave modport is
// the arbiter's view. The master modport is the view of whatever surrounds it:
// the fetch unit, the load/store unit and the memory.
//
// Signals:
//   if_req, if_addr, if_pf_addr          fetch request and its opcode/prefetch addresses
//   if_opc, if_pf_opc, if_done, hold     fetched word pair, completion pulse, fetch stall
//   ls_req, ls_we, ls_addr, ls_wdata     load/store request
//   ls_rdata, ls_done                    load data and completion pulse
//   mem_en, mem_we, mem_addr, mem_wdata  memory access strobe and write side
//   mem_rdata, mem_ready                 memory read data and access-complete
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [ADDR_W-1:0] if_pf_addr;
  logic [DATA_W-1:0] if_opc;
  logic [DATA_W-1:0] if_pf_opc;
  logic              if_done;
  logic              hold;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_done;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  if_req, if_addr, if_pf_addr,
    output if_opc, if_pf_opc, if_done, hold,
    input  ls_req, ls_we, ls_addr, ls_wdata,
    output ls_rdata, ls_done,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output if_req, if_addr, if_pf_addr,
    input  if_opc, if_pf_opc, if_done, hold,
    output ls_req, ls_we, ls_addr, ls_wdata,
    input  ls_rdata, ls_done,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - Arbiter sharing one 16-bit memory port between instruction fetch and load/store
//
// Instruction fetch needs a pair of words: the opcode and the prefetch word.
// This block issues that pair as an atomic two-beat sequence, arbitrates it
// against single-beat load/store accesses, and drives hold to stall the
// fetch unit and decoder until the pair has been delivered.
//
// Optional feature, macro MEM_PORT_ARB_REUSE_EN: a one-entry buffer holds the
// last prefetch word. A fetch whose opcode address equals the previous prefetch
// address takes its opcode from the buffer and issues only the prefetch beat.
//
// Ports:
//   clk    in   core clock, rising edge
//   a_rst  in   asynchronous active-low reset; drops any in-flight access
//   bus    slave modport of mem_port_arbiter_if:
//            fetch side      if_req/if_addr/if_pf_addr in, if_opc/if_pf_opc/if_done/hold out
//            load/store side ls_req/ls_we/ls_addr/ls_wdata in, ls_rdata/ls_done out
//            memory side     mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ready in
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              a_rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_IF_LO = 2'd1,
    S_IF_HI = 2'd2,
    S_LS    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // 0: load/store wins a tie, 1: fetch wins a tie
  logic              r_pri;

  logic [DATA_W-1:0] r_if_opc;
  logic [DATA_W-1:0] r_if_pf_opc;
  logic [DATA_W-1:0] r_ls_rdata;
  logic              r_if_done;
  logic              r_ls_done;

  logic              w_if_elig;
  logic              w_ls_elig;
  logic              w_hit;

  logic              w_mem_en;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  logic              w_if_lo_fire;
  logic              w_if_hi_fire;
  logic              w_ls_fire;

  // A requester whose done pulse is high this cycle still shows its old
  // request; ignoring it here keeps that stale request from issuing twice.
  assign w_if_elig = bus.if_req & ~r_if_done;
  assign w_ls_elig = bus.ls_req & ~r_ls_done;

  assign w_if_lo_fire = (r_state == S_IF_LO) & bus.mem_ready;
  assign w_if_hi_fire = (r_state == S_IF_HI) & bus.mem_ready;
  assign w_ls_fire    = (r_state == S_LS)    & bus.mem_ready;

`ifdef MEM_PORT_ARB_REUSE_EN
  logic              r_buf_valid;
  logic [ADDR_W-1:0] r_last_pf_addr;
  logic [DATA_W-1:0] r_last_pf_data;

  // Any completed write may have changed the buffered word, so it invalidates
  // the buffer regardless of address.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      r_buf_valid    <= 1'b0;
      r_last_pf_addr <= '0;
      r_last_pf_data <= '0;
    end else if (w_if_hi_fire) begin
      r_buf_valid    <= 1'b1;
      r_last_pf_addr <= bus.if_pf_addr;
      r_last_pf_data <= bus.mem_rdata;
    end else if (w_ls_fire && bus.ls_we) begin
      r_buf_valid    <= 1'b0;
    end
  end

  assign w_hit = r_buf_valid & (bus.if_addr == r_last_pf_addr);
`else
  assign w_hit = 1'b0;
`endif

  // Next-state and memory-port decode
  always_comb begin
    w_state_nxt = r_state;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;

    case (r_state)
      S_IDLE: begin
        if (w_if_elig && (!w_ls_elig || r_pri)) begin
          w_state_nxt = w_hit ? S_IF_HI : S_IF_LO;
        end else if (w_ls_elig) begin
          w_state_nxt = S_LS;
        end
      end

      S_IF_LO: begin
        w_mem_en   = 1'b1;
        w_mem_addr = bus.if_addr;
        if (bus.mem_ready) begin
          w_state_nxt = S_IF_HI;
        end
      end

      S_IF_HI: begin
        w_mem_en   = 1'b1;
        w_mem_addr = bus.if_pf_addr;
        if (bus.mem_ready) begin
          w_state_nxt = S_IDLE;
        end
      end

      S_LS: begin
        w_mem_en    = 1'b1;
        w_mem_we    = bus.ls_we;
        w_mem_addr  = bus.ls_addr;
        w_mem_wdata = bus.ls_wdata;
        if (bus.mem_ready) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register, captured data and completion pulses
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      r_state     <= S_IDLE;
      r_pri       <= 1'b0;
      r_if_opc    <= '0;
      r_if_pf_opc <= '0;
      r_ls_rdata  <= '0;
      r_if_done   <= 1'b0;
      r_ls_done   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_if_done <= w_if_hi_fire;
      r_ls_done <= w_ls_fire;

      if (w_if_lo_fire) begin
        r_if_opc <= bus.mem_rdata;
      end
`ifdef MEM_PORT_ARB_REUSE_EN
      else if ((r_state == S_IDLE) && (w_state_nxt == S_IF_HI)) begin
        // Buffer hit: the opcode word is already on hand, load it at grant.
        r_if_opc <= r_last_pf_data;
      end
`endif

      // Fairness: a finished load/store hands the next tie to fetch, and a
      // finished fetch pair hands it back.
      if (w_if_hi_fire) begin
        r_if_pf_opc <= bus.mem_rdata;
        r_pri       <= 1'b0;
      end

      if (w_ls_fire) begin
        r_pri <= 1'b1;
        if (!bus.ls_we) begin
          r_ls_rdata <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;

  assign bus.if_opc    = r_if_opc;
  assign bus.if_pf_opc = r_if_pf_opc;
  assign bus.if_done   = r_if_done;
  assign bus.ls_rdata  = r_ls_rdata;
  assign bus.ls_done   = r_ls_done;

  // Falls in the if_done cycle so the fetch unit resumes with the pair in hand.
  assign bus.hold = bus.if_req & ~r_if_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - Directed and randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

`ifdef MEM_PORT_ARB_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic a_rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .a_rst (a_rst),
    .bus   (bus)
  );

  // Memory responder and reference image
  logic [15:0] mem_arr [0:65535];
  logic [15:0] ref_mem [0:65535];

  assign bus.mem_rdata = mem_arr[bus.mem_addr];

  always @(posedge clk) begin
    if (a_rst && bus.mem_en && bus.mem_we && bus.mem_ready)
      mem_arr[bus.mem_addr] = bus.mem_wdata;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level scoreboard: every access the memory completes is queued,
  // and each done pulse must account for exactly its own accesses.
  logic [15:0] q_addr [$];
  logic        q_we   [$];
  logic        prev_ifd, prev_lsd;
  int          ls_while_if;
  logic        buf_v;
  logic [15:0] buf_addr;
  logic [15:0] last_rd;

  always @(negedge clk) begin
    int exp_n;
    if (!a_rst) begin
      q_addr.delete();
      q_we.delete();
      prev_ifd    = 1'b0;
      prev_lsd    = 1'b0;
      ls_while_if = 0;
      buf_v       = 1'b0;
      last_rd     = 16'h0;
    end else begin
      check("hold", bus.hold, bus.if_req & ~bus.if_done);
      if (bus.mem_en && bus.mem_ready) begin
        q_addr.push_back(bus.mem_addr);
        q_we.push_back(bus.mem_we);
      end
      if (bus.if_done) begin
        check("if_done_width", prev_ifd, 1'b0);
        check("if_opc", bus.if_opc, ref_mem[bus.if_addr]);
        check("if_pf_opc", bus.if_pf_opc, ref_mem[bus.if_pf_addr]);
        exp_n = (REUSE && buf_v && (buf_addr == bus.if_addr)) ? 1 : 2;
        check("if_beats", q_addr.size(), exp_n);
        if (q_addr.size() == exp_n) begin
          if (exp_n == 2) check("if_lo_addr", q_addr[0], bus.if_addr);
          check("if_hi_addr", q_addr[exp_n-1], bus.if_pf_addr);
          foreach (q_we[i]) check("if_we", q_we[i], 1'b0);
        end
        buf_v       = 1'b1;
        buf_addr    = bus.if_pf_addr;
        ls_while_if = 0;
        q_addr.delete();
        q_we.delete();
      end
      if (bus.ls_done) begin
        check("ls_done_width", prev_lsd, 1'b0);
        check("ls_beats", q_addr.size(), 1);
        if (q_addr.size() == 1) begin
          check("ls_addr", q_addr[0], bus.ls_addr);
          check("ls_we", q_we[0], bus.ls_we);
        end
        if (bus.ls_we) begin
          ref_mem[bus.ls_addr] = bus.ls_wdata;
          buf_v = 1'b0;
          check("ls_rdata_kept", bus.ls_rdata, last_rd);
        end else begin
          check("ls_rdata", bus.ls_rdata, ref_mem[bus.ls_addr]);
          last_rd = ref_mem[bus.ls_addr];
        end
        if (bus.if_req) begin
          ls_while_if++;
          check("fetch_not_starved", ls_while_if, 1);
        end
        q_addr.delete();
        q_we.delete();
      end
      prev_ifd = bus.if_done;
      prev_lsd = bus.ls_done;
    end
  end

  // Per-cycle capture for directed timing checks
  logic        s_en [0:15], s_we [0:15], s_ifd [0:15], s_lsd [0:15], s_hold [0:15];
  logic [15:0] s_addr [0:15], s_wd [0:15], s_opc [0:15], s_pf [0:15], s_rd [0:15];

  task automatic rec(input int k);
    s_en[k]   = bus.mem_en;
    s_we[k]   = bus.mem_we;
    s_addr[k] = bus.mem_addr;
    s_wd[k]   = bus.mem_wdata;
    s_ifd[k]  = bus.if_done;
    s_lsd[k]  = bus.ls_done;
    s_hold[k] = bus.hold;
    s_opc[k]  = bus.if_opc;
    s_pf[k]   = bus.if_pf_opc;
    s_rd[k]   = bus.ls_rdata;
  endtask

  // Cycle k is sampled at a negedge; rdy[k] is the mem_ready applied after it.
  task automatic run(input int n, input logic [15:0] rdy, input bit keep_ls);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rec(k);
      @(posedge clk);
      #1;
      if (s_lsd[k] && !keep_ls) bus.ls_req = 1'b0;
      if (s_ifd[k]) bus.if_req = 1'b0;
      bus.mem_ready = rdy[k];
    end
  endtask

  task automatic do_reset();
    a_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b1;
  endtask

  task automatic fetch(input logic [15:0] a, input logic [15:0] pa);
    bus.if_addr    = a;
    bus.if_pf_addr = pa;
    bus.if_req     = 1'b1;
  endtask

  task automatic lsreq(input logic we, input logic [15:0] a, input logic [15:0] d);
    bus.ls_we    = we;
    bus.ls_addr  = a;
    bus.ls_wdata = d;
    bus.ls_req   = 1'b1;
  endtask

  bit stop_rdy;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    for (int i = 0; i < 65536; i++) begin
      mem_arr[i] = 16'(i * 7) ^ 16'hC3A5;
    end
    mem_arr[16'h0100] = 16'hA9F0;
    mem_arr[16'h0102] = 16'h1234;
    mem_arr[16'h0104] = 16'h7E57;
    mem_arr[16'h2000] = 16'h5555;
    for (int i = 0; i < 65536; i++) ref_mem[i] = mem_arr[i];

    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_pf_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;
    bus.mem_ready = 1'b1;
    do_reset();

    // Reset while stalled in the prefetch beat
    fetch(16'h0100, 16'h0102);
    run(2, 16'hFFFD, 1'b0);
    @(negedge clk);
    check("t1_in_if_hi_addr", bus.mem_addr, 16'h0102);
    check("t1_in_if_hi_en", bus.mem_en, 1'b1);
    #2 a_rst = 1'b0;
    #1 check("t1_en_in_reset", bus.mem_en, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    a_rst = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("t1_mem_en", bus.mem_en, 1'b0);
    check("t1_mem_we", bus.mem_we, 1'b0);
    check("t1_if_done", bus.if_done, 1'b0);
    check("t1_hold", bus.hold, 1'b1);
    check("t1_if_opc", bus.if_opc, 16'h0);
    check("t1_if_pf_opc", bus.if_pf_opc, 16'h0);
    check("t1_ls_rdata", bus.ls_rdata, 16'h0);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.if_done) begin ok = 1'b1; break; end
    end
    check("t1_refetch_timeout", ok, 1'b1);
    @(posedge clk);
    #1 bus.if_req = 1'b0;

    // Fetch only, zero wait states
    do_reset();
    fetch(16'h0100, 16'h0102);
    run(4, 16'hFFFF, 1'b0);
    check("t2_idle_en", s_en[0], 1'b0);
    check("t2_hold_n", s_hold[0], 1'b1);
    check("t2_addr_lo", s_addr[1], 16'h0100);
    check("t2_hold_n1", s_hold[1], 1'b1);
    check("t2_addr_hi", s_addr[2], 16'h0102);
    check("t2_hold_n2", s_hold[2], 1'b1);
    check("t2_done_early", s_ifd[2], 1'b0);
    check("t2_done_n3", s_ifd[3], 1'b1);
    check("t2_hold_n3", s_hold[3], 1'b0);
    check("t2_opc", s_opc[3], 16'hA9F0);
    check("t2_pf_opc", s_pf[3], 16'h1234);

    // Conflict after reset: load/store first
    do_reset();
    fetch(16'h0100, 16'h0102);
    lsreq(1'b0, 16'h2000, 16'h0);
    run(6, 16'hFFFF, 1'b0);
    check("t3_ls_addr", s_addr[1], 16'h2000);
    check("t3_ls_done_n2", s_lsd[2], 1'b1);
    check("t3_ls_rdata", s_rd[2], 16'h5555);
    check("t3_if_lo", s_addr[3], 16'h0100);
    check("t3_if_hi", s_addr[4], 16'h0102);
    check("t3_if_done", s_ifd[5], 1'b1);

    // After a load/store completes, the next tie goes to fetch
    lsreq(1'b0, 16'h2000, 16'h0);
    run(3, 16'hFFFF, 1'b0);
    check("t3b_ls_done", s_lsd[2], 1'b1);
    fetch(16'h0100, 16'h0102);
    lsreq(1'b0, 16'h2000, 16'h0);
    run(6, 16'hFFFF, 1'b0);
    check("t3b_if_first", s_addr[1], 16'h0100);
    check("t3b_if_done", s_ifd[3], 1'b1);
    check("t3b_ls_after", s_addr[4], 16'h2000);
    check("t3b_ls_done", s_lsd[5], 1'b1);

    // Write with three wait states
    lsreq(1'b1, 16'h3000, 16'hBEEF);
    bus.mem_ready = 1'b0;
    run(7, 16'hFFF8, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      check("t4_en", s_en[k], 1'b1);
      check("t4_we", s_we[k], 1'b1);
      check("t4_addr", s_addr[k], 16'h3000);
      check("t4_wdata", s_wd[k], 16'hBEEF);
    end
    check("t4_no_early_done", s_lsd[4], 1'b0);
    check("t4_done", s_lsd[5], 1'b1);
    check("t4_done_width", s_lsd[6], 1'b0);
    check("t4_rdata_kept", s_rd[5], 16'h5555);
    check("t4_mem_written", mem_arr[16'h3000], 16'hBEEF);

    // Stale load/store request across its done pulse
    lsreq(1'b0, 16'h2000, 16'h0);
    run(6, 16'hFFFF, 1'b1);
    bus.ls_req = 1'b0;
    check("t5_done1", s_lsd[2], 1'b1);
    check("t5_no_issue_in_done", s_en[2], 1'b0);
    check("t5_second_access", s_en[4], 1'b1);
    check("t5_done2", s_lsd[5], 1'b1);

`ifdef MEM_PORT_ARB_REUSE_EN
    // Buffered prefetch word reused by a sequential fetch
    do_reset();
    fetch(16'h0100, 16'h0102);
    run(4, 16'hFFFF, 1'b0);
    check("t6_first_done", s_ifd[3], 1'b1);
    fetch(16'h0102, 16'h0104);
    run(3, 16'hFFFF, 1'b0);
    check("t6_grant_idle", s_en[0], 1'b0);
    check("t6_single_addr", s_addr[1], 16'h0104);
    check("t6_done_2", s_ifd[2], 1'b1);
    check("t6_opc", s_opc[2], 16'h1234);
    check("t6_pf_opc", s_pf[2], 16'h7E57);
    lsreq(1'b1, 16'h3000, 16'h1111);
    run(3, 16'hFFFF, 1'b0);
    fetch(16'h0104, 16'h0106);
    run(4, 16'hFFFF, 1'b0);
    check("t6_two_beat_lo", s_addr[1], 16'h0104);
    check("t6_two_beat_hi", s_addr[2], 16'h0106);
    check("t6_two_beat_done", s_ifd[3], 1'b1);
`endif

    // Randomized traffic against the scoreboard
    do_reset();
    stop_rdy = 1'b0;
    fork
      begin
        fork
          begin
            logic [15:0] pc;
            bit fok;
            pc = 16'h4000;
            for (int t = 0; t < 60; t++) begin
              repeat ($urandom_range(0, 3)) @(posedge clk);
              #1;
              if ($urandom_range(0, 1) == 0) pc = 16'h4000 | (16'($urandom_range(0, 127)) << 1);
              fetch(pc, pc + 16'd2);
              fok = 1'b0;
              for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if (bus.if_done) begin fok = 1'b1; break; end
              end
              check("rand_fetch_timeout", fok, 1'b1);
              @(posedge clk);
              #1 bus.if_req = 1'b0;
              pc = pc + 16'd2;
            end
          end
          begin
            bit lok;
            for (int t = 0; t < 60; t++) begin
              repeat ($urandom_range(0, 4)) @(posedge clk);
              #1;
              lsreq(1'($urandom_range(0, 1)), 16'h4000 | (16'($urandom_range(0, 127)) << 1),
                    16'($urandom));
              lok = 1'b0;
              for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if (bus.ls_done) begin lok = 1'b1; break; end
              end
              check("rand_ls_timeout", lok, 1'b1);
              @(posedge clk);
              #1 bus.ls_req = 1'b0;
            end
          end
        join
        stop_rdy = 1'b1;
      end
      begin
        while (!stop_rdy) begin
          @(posedge clk);
          #1 bus.mem_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
